// File: rtl/core_pkg.sv
// Shared core types: opcode map, destination one-hot and the
// routed operand beat carried from register read into execute.
package core_pkg;

    localparam int RT_N  = 16;
    localparam int RT_AW = 4;

    localparam logic [3:0] OP_ALU_R0 = 4'h0;
    localparam logic [3:0] OP_ALU_R3 = 4'h3;
    localparam logic [3:0] OP_ALU_I0 = 4'h4;
    localparam logic [3:0] OP_ALU_I3 = 4'h7;
    localparam logic [3:0] OP_ST0    = 4'h8;
    localparam logic [3:0] OP_ST1    = 4'h9;
    localparam logic [3:0] OP_BR0    = 4'hA;
    localparam logic [3:0] OP_BR1    = 4'hB;

    typedef logic [2:0] dest_t;

    localparam dest_t DEST_NONE = 3'b000;
    localparam dest_t DEST_ALU  = 3'b001;
    localparam dest_t DEST_MEM  = 3'b010;
    localparam dest_t DEST_BR   = 3'b100;

    typedef struct packed {
        logic [RT_N-1:0] inp2;
        dest_t           dest_oh;
        logic            fwd_hit;
    } route_beat_t;

endpackage

// File: rtl/rs2_route_stage_if.sv
// Handshake bundle for the rs2 routing stage: upstream beat, writeback
// bypass, downstream beat and stall counter. master = driver side.
interface rs2_route_stage_if #(
    parameter int N     = 16,
    parameter int AW    = 4,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op_code;
    logic [AW-1:0]    rs2_addr;
    logic [N-1:0]     rs2_in;
    logic [N-1:0]     imm_in;
    logic             wb_en;
    logic [AW-1:0]    wb_addr;
    logic [N-1:0]     wb_data;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     inp2;
    logic [2:0]       dest_oh;
    logic             fwd_hit;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output in_valid, op_code, rs2_addr, rs2_in, imm_in,
        output wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, inp2, dest_oh, fwd_hit, stall_cnt
    );

    modport slave (
        input  in_valid, op_code, rs2_addr, rs2_in, imm_in,
        input  wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, inp2, dest_oh, fwd_hit, stall_cnt
    );
endinterface

// File: rtl/rs2_route_decode.sv
// Opcode decode for operand-2 routing.
// Ports: op_code_i -> dest_oh_o (one-hot), use_imm_o, uses_rs2_o.
module rs2_route_decode
    import core_pkg::*;
(
    input  logic [3:0] op_code_i,
    output dest_t      dest_oh_o,
    output logic       use_imm_o,
    output logic       uses_rs2_o
);

    always_comb begin
        dest_oh_o  = DEST_NONE;
        use_imm_o  = 1'b0;
        uses_rs2_o = 1'b0;
        unique case (1'b1)
            op_code_i inside {[OP_ALU_R0:OP_ALU_R3]}: begin
                dest_oh_o  = DEST_ALU;
                uses_rs2_o = 1'b1;
            end
            op_code_i inside {[OP_ALU_I0:OP_ALU_I3]}: begin
                dest_oh_o = DEST_ALU;
                use_imm_o = 1'b1;
            end
            op_code_i inside {[OP_ST0:OP_ST1]}: begin
                dest_oh_o  = DEST_MEM;
                uses_rs2_o = 1'b1;
            end
            op_code_i inside {[OP_BR0:OP_BR1]}: begin
                dest_oh_o  = DEST_BR;
                uses_rs2_o = 1'b1;
            end
            default: begin
                dest_oh_o = DEST_NONE;
            end
        endcase
    end

endmodule

// File: rtl/rs2_route_stage.sv
// Registered operand-2 routing stage with bypass and 2-entry skid buffer.
// Ports: clk, rst (sync, active-high), bus (slave side of rs2_route_stage_if).
module rs2_route_stage
    import core_pkg::*;
#(
    parameter int N     = RT_N,
    parameter int AW    = RT_AW,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    rs2_route_stage_if.slave       bus
);

    dest_t            dec_dest;
    logic             dec_imm;
    logic             dec_rs2;
    logic             fwd_sel;
    logic [N-1:0]     rs2_val;
    route_beat_t      in_beat;

    route_beat_t      main_q, main_d;
    route_beat_t      skid_q, skid_d;
    logic             main_v_q, main_v_d;
    logic             skid_v_q, skid_v_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic             accept;
    logic             fire;

    rs2_route_decode u_dec (
        .op_code_i  (bus.op_code),
        .dest_oh_o  (dec_dest),
        .use_imm_o  (dec_imm),
        .uses_rs2_o (dec_rs2)
    );

    // Bypass only for rs2-sourced ops; register 0 is not special here.
    assign fwd_sel = dec_rs2 & bus.wb_en
                   & (bus.wb_addr[AW-1:0] == bus.rs2_addr[AW-1:0]);
    assign rs2_val = fwd_sel ? bus.wb_data : bus.rs2_in;

    always_comb begin
        in_beat         = '0;
        in_beat.dest_oh = dec_dest;
        if (dec_imm) begin
            in_beat.inp2 = bus.imm_in;
        end else if (dec_rs2) begin
            in_beat.inp2    = rs2_val;
            in_beat.fwd_hit = fwd_sel;
        end
    end

    // in_ready comes only from skid occupancy, never from out_ready.
    assign accept = bus.in_valid & ~skid_v_q;
    assign fire   = main_v_q & bus.out_ready;

    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        if (fire) begin
            if (skid_v_q) begin
                main_d   = skid_q;
                skid_v_d = 1'b0;
            end else begin
                main_v_d = accept;
                if (accept) main_d = in_beat;
            end
        end else if (accept) begin
            if (main_v_q) begin
                skid_d   = in_beat;
                skid_v_d = 1'b1;
            end else begin
                main_d   = in_beat;
                main_v_d = 1'b1;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (main_v_q && !bus.out_ready && !(&stall_q)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            stall_q  <= '0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            stall_q  <= stall_d;
        end
    end

    assign bus.in_ready  = ~skid_v_q;
    assign bus.out_valid = main_v_q;
    assign bus.inp2      = main_q.inp2;
    assign bus.dest_oh   = main_q.dest_oh;
    assign bus.fwd_hit   = main_q.fwd_hit;
    assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_rs2_route_stage.sv
// Self-checking bench for rs2_route_stage: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_rs2_route_stage;

    typedef struct {
        logic [15:0] v;
        logic [2:0]  d;
        logic        f;
    } exp_beat_t;

    logic clk;
    logic rst;
    int   nchk;
    int   nerr;

    exp_beat_t q[$];
    int        m_stall;

    rs2_route_stage_if #(.N(16), .AW(4), .CNT_W(4)) bus ();

    rs2_route_stage #(.N(16), .AW(4), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_beat_t ref_beat(
        input logic [3:0]  op,
        input logic [3:0]  a,
        input logic [15:0] r,
        input logic [15:0] imm,
        input logic        wen,
        input logic [3:0]  wa,
        input logic [15:0] wd
    );
        exp_beat_t b;
        int        src;
        int        o;
        o   = int'(op);
        src = 0;
        b.v = 16'h0;
        b.d = 3'b000;
        b.f = 1'b0;
        if (o < 4) begin
            b.d = 3'b001;
            src = 1;
        end else if (o < 8) begin
            b.d = 3'b001;
            src = 2;
        end else if (o < 10) begin
            b.d = 3'b010;
            src = 1;
        end else if (o < 12) begin
            b.d = 3'b100;
            src = 1;
        end
        if (src == 2) b.v = imm;
        if (src == 1) begin
            if (wen && wa == a) begin
                b.v = wd;
                b.f = 1'b1;
            end else begin
                b.v = r;
            end
        end
        return b;
    endfunction

    task automatic drive(
        input logic        vld,
        input logic [3:0]  op,
        input logic [3:0]  a,
        input logic [15:0] r,
        input logic [15:0] imm,
        input logic        wen,
        input logic [3:0]  wa,
        input logic [15:0] wd
    );
        bus.in_valid = vld;
        bus.op_code  = op;
        bus.rs2_addr = a;
        bus.rs2_in   = r;
        bus.imm_in   = imm;
        bus.wb_en    = wen;
        bus.wb_addr  = wa;
        bus.wb_data  = wd;
    endtask

    // Advance one clock and keep the reference model in step.
    task automatic tick();
        bit        acc;
        bit        fire;
        bit        stall;
        exp_beat_t nb;
        acc   = bus.in_valid && (q.size() < 2);
        fire  = (q.size() > 0) && bus.out_ready;
        stall = (q.size() > 0) && !bus.out_ready;
        nb    = ref_beat(bus.op_code, bus.rs2_addr, bus.rs2_in,
                         bus.imm_in, bus.wb_en, bus.wb_addr,
                         bus.wb_data);
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_stall = 0;
        end else begin
            if (fire) void'(q.pop_front());
            if (acc) q.push_back(nb);
            if (stall && m_stall < 15) m_stall++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 4'h2, 4'h1, 16'h5555, 16'h0, 1'b0, 4'h0, 16'h0);
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0);
        nchk++;
        if (bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        end
        nchk++;
        if (bus.in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
        nchk++;
        if (bus.stall_cnt !== 4'h0) begin
            nerr++;
            $display("FAIL reset_stall got=%h exp=0", bus.stall_cnt);
        end
        nchk++;
        if ({bus.inp2, bus.dest_oh, bus.fwd_hit} !== 20'h0) begin
            nerr++;
            $display("FAIL reset_fields got=%h/%b/%b exp=0",
                     bus.inp2, bus.dest_oh, bus.fwd_hit);
        end
        tick();
        nchk++;
        if (bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL reset_no_beat got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_alu_reg();
        bus.out_ready = 1'b1;
        drive(1'b1, 4'h2, 4'h3, 16'h1234, 16'h0, 1'b0, 4'h0, 16'h0);
        tick();
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0);
        nchk++;
        if (bus.out_valid !== 1'b1 || bus.inp2 !== 16'h1234 ||
            bus.dest_oh !== 3'b001 || bus.fwd_hit !== 1'b0) begin
            nerr++;
            $display("FAIL alu_reg got=%b/%h/%b/%b exp=1/1234/001/0",
                     bus.out_valid, bus.inp2, bus.dest_oh, bus.fwd_hit);
        end
        tick();
        nchk++;
        if (bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL alu_reg_drain got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_bypass();
        bus.out_ready = 1'b1;
        drive(1'b1, 4'h0, 4'h5, 16'h0011, 16'h0, 1'b1, 4'h5, 16'hABCD);
        tick();
        drive(1'b1, 4'h5, 4'h5, 16'h0011, 16'h0007, 1'b1, 4'h5, 16'hABCD);
        nchk++;
        if (bus.inp2 !== 16'hABCD || bus.fwd_hit !== 1'b1 ||
            bus.dest_oh !== 3'b001) begin
            nerr++;
            $display("FAIL bypass_rs2 got=%h/%b/%b exp=abcd/1/001",
                     bus.inp2, bus.fwd_hit, bus.dest_oh);
        end
        tick();
        drive(1'b1, 4'h9, 4'h0, 16'h1111, 16'h0, 1'b1, 4'h0, 16'h5A5A);
        nchk++;
        if (bus.inp2 !== 16'h0007 || bus.fwd_hit !== 1'b0 ||
            bus.out_valid !== 1'b1) begin
            nerr++;
            $display("FAIL bypass_imm got=%h/%b/%b exp=0007/0/1",
                     bus.inp2, bus.fwd_hit, bus.out_valid);
        end
        tick();
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0);
        nchk++;
        if (bus.inp2 !== 16'h5A5A || bus.fwd_hit !== 1'b1 ||
            bus.dest_oh !== 3'b010) begin
            nerr++;
            $display("FAIL bypass_r0 got=%h/%b/%b exp=5a5a/1/010",
                     bus.inp2, bus.fwd_hit, bus.dest_oh);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int s0;
        s0            = m_stall;
        bus.out_ready = 1'b0;
        drive(1'b1, 4'h1, 4'h2, 16'hAAAA, 16'h0, 1'b0, 4'h0, 16'h0);
        tick();
        nchk++;
        if (bus.in_ready !== 1'b1 || bus.inp2 !== 16'hAAAA ||
            bus.stall_cnt !== 4'(s0)) begin
            nerr++;
            $display("FAIL b2b_a got=%b/%h/%h exp=1/aaaa/%h",
                     bus.in_ready, bus.inp2, bus.stall_cnt, 4'(s0));
        end
        drive(1'b1, 4'h1, 4'h2, 16'hBBBB, 16'h0, 1'b0, 4'h0, 16'h0);
        tick();
        nchk++;
        if (bus.in_ready !== 1'b0 || bus.inp2 !== 16'hAAAA ||
            bus.stall_cnt !== 4'(s0 + 1)) begin
            nerr++;
            $display("FAIL b2b_b got=%b/%h/%h exp=0/aaaa/%h",
                     bus.in_ready, bus.inp2, bus.stall_cnt, 4'(s0 + 1));
        end
        drive(1'b1, 4'h1, 4'h2, 16'hCCCC, 16'h0, 1'b0, 4'h0, 16'h0);
        tick();
        nchk++;
        if (bus.in_ready !== 1'b0 || bus.inp2 !== 16'hAAAA ||
            bus.out_valid !== 1'b1 || bus.stall_cnt !== 4'(s0 + 2)) begin
            nerr++;
            $display("FAIL b2b_held got=%b/%h/%h exp=0/aaaa/%h",
                     bus.in_ready, bus.inp2, bus.stall_cnt, 4'(s0 + 2));
        end
        bus.out_ready = 1'b1;
        tick();
        nchk++;
        if (bus.out_valid !== 1'b1 || bus.inp2 !== 16'hBBBB ||
            bus.in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL b2b_rel_b got=%b/%h/%b exp=1/bbbb/1",
                     bus.out_valid, bus.inp2, bus.in_ready);
        end
        tick();
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0);
        nchk++;
        if (bus.out_valid !== 1'b1 || bus.inp2 !== 16'hCCCC) begin
            nerr++;
            $display("FAIL b2b_rel_c got=%b/%h exp=1/cccc",
                     bus.out_valid, bus.inp2);
        end
        tick();
        nchk++;
        if (bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_empty got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_dest();
        bus.out_ready = 1'b1;
        drive(1'b1, 4'h8, 4'h1, 16'h0101, 16'h0, 1'b0, 4'h0, 16'h0);
        tick();
        drive(1'b1, 4'hB, 4'h1, 16'h0202, 16'h0, 1'b0, 4'h0, 16'h0);
        nchk++;
        if (bus.dest_oh !== 3'b010 || bus.inp2 !== 16'h0101) begin
            nerr++;
            $display("FAIL dest_mem got=%b/%h exp=010/0101",
                     bus.dest_oh, bus.inp2);
        end
        tick();
        drive(1'b1, 4'hE, 4'h4, 16'hFFFF, 16'h0, 1'b1, 4'h4, 16'h9999);
        nchk++;
        if (bus.dest_oh !== 3'b100 || bus.inp2 !== 16'h0202) begin
            nerr++;
            $display("FAIL dest_br got=%b/%h exp=100/0202",
                     bus.dest_oh, bus.inp2);
        end
        tick();
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0);
        nchk++;
        if (bus.out_valid !== 1'b1 || bus.dest_oh !== 3'b000 ||
            bus.inp2 !== 16'h0000 || bus.fwd_hit !== 1'b0) begin
            nerr++;
            $display("FAIL dest_none got=%b/%b/%h/%b exp=1/000/0000/0",
                     bus.out_valid, bus.dest_oh, bus.inp2, bus.fwd_hit);
        end
        tick();
    endtask

    task automatic test_stall_sat();
        bus.out_ready = 1'b0;
        drive(1'b1, 4'h3, 4'h7, 16'h7777, 16'h0, 1'b0, 4'h0, 16'h0);
        tick();
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0);
        for (int i = 0; i < 20; i++) tick();
        nchk++;
        if (bus.stall_cnt !== 4'hF || bus.out_valid !== 1'b1 ||
            bus.inp2 !== 16'h7777) begin
            nerr++;
            $display("FAIL stall_sat got=%h/%b/%h exp=f/1/7777",
                     bus.stall_cnt, bus.out_valid, bus.inp2);
        end
    endtask

    task automatic test_reset_mid_stall();
        bus.out_ready = 1'b0;
        drive(1'b1, 4'h6, 4'h0, 16'h0, 16'h4321, 1'b0, 4'h0, 16'h0);
        tick();
        nchk++;
        if (bus.in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL rst_mid_full got=%b exp=0", bus.in_ready);
        end
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0);
        nchk++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.stall_cnt !== 4'h0) begin
            nerr++;
            $display("FAIL rst_mid got=%b/%b/%h exp=0/1/0",
                     bus.out_valid, bus.in_ready, bus.stall_cnt);
        end
        tick();
        nchk++;
        if (bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL rst_mid_drop got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.out_ready = ($urandom_range(0, 2) != 0);
            drive($urandom_range(0, 3) != 0,
                  4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 3)),
                  16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 3)),
                  16'($urandom));
            nchk++;
            if (bus.out_valid !== (q.size() > 0) ||
                bus.in_ready !== (q.size() < 2)) begin
                nerr++;
                $display("FAIL rnd_flags cyc=%0d got=%b/%b exp=%b/%b", i,
                         bus.out_valid, bus.in_ready,
                         q.size() > 0, q.size() < 2);
            end
            nchk++;
            if (bus.stall_cnt !== 4'(m_stall)) begin
                nerr++;
                $display("FAIL rnd_stall cyc=%0d got=%h exp=%h", i,
                         bus.stall_cnt, 4'(m_stall));
            end
            if (q.size() > 0) begin
                nchk++;
                if (bus.inp2 !== q[0].v || bus.dest_oh !== q[0].d ||
                    bus.fwd_hit !== q[0].f) begin
                    nerr++;
                    $display("FAIL rnd_beat cyc=%0d got=%h/%b/%b exp=%h/%b/%b",
                             i, bus.inp2, bus.dest_oh, bus.fwd_hit,
                             q[0].v, q[0].d, q[0].f);
                end
            end
            tick();
        end
        bus.out_ready = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0);
        tick();
        tick();
        tick();
        nchk++;
        if (bus.out_valid !== 1'b0 || q.size() != 0) begin
            nerr++;
            $display("FAIL rnd_drain got=%b exp=0 model=%0d",
                     bus.out_valid, q.size());
        end
    endtask

    initial begin
        nchk    = 0;
        nerr    = 0;
        m_stall = 0;
        rst     = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0);
        test_reset();
        test_alu_reg();
        test_bypass();
        test_back_to_back();
        test_dest();
        test_stall_sat();
        test_reset_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
